// File: rtl/multicycle_ctrl.sv
// Control unit for the multicycle ARM processor: main FSM, ALU decoder,
// conditional-execution logic with NZCV flags, and PC-write logic.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  state_t     state;
  logic [3:0] flags;
  logic       cond_ex_reg;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       alu_op;
  logic [1:0] flag_w;
  logic       unused_instr;

  assign cond         = Instr[31:28];
  assign op           = Instr[27:26];
  assign funct        = Instr[25:20];
  assign rd           = Instr[15:12];
  assign unused_instr = ^Instr[11:0];
  assign alu_op       = (state == EXECUTER) || (state == EXECUTEI);

  function automatic logic cond_ex(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = !z;
      4'b0010: cond_ex = cy;
      4'b0011: cond_ex = !cy;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = !n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = !v;
      4'b1000: cond_ex = cy && !z;
      4'b1001: cond_ex = !cy || z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = !z && (n == v);
      4'b1101: cond_ex = z || (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    ALUControl = 2'b00;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (funct[4:1])
        4'b0100: begin ALUControl = 2'b00; flag_w = {funct[0], funct[0]}; end
        4'b0010: begin ALUControl = 2'b01; flag_w = {funct[0], funct[0]}; end
        4'b0000: begin ALUControl = 2'b10; flag_w = {funct[0], 1'b0};     end
        4'b1100: begin ALUControl = 2'b11; flag_w = {funct[0], 1'b0};     end
        default: begin ALUControl = 2'b00; flag_w = 2'b00;                end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      flags       <= 4'b0000;
      cond_ex_reg <= 1'b0;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          cond_ex_reg <= cond_ex(cond, flags);
          case (op)
            2'b01:   state <= MEMADR;
            2'b10:   state <= BRANCH;
            2'b00:   state <= funct[5] ? EXECUTEI : EXECUTER;
            default: state <= FETCH;
          endcase
        end
        MEMADR:             state <= funct[0] ? MEMRD : MEMWR;
        MEMRD:              state <= MEMWB;
        EXECUTER, EXECUTEI: state <= ALUWB;
        default:            state <= FETCH;
      endcase
      // Flags are captured from the ALU on the edge leaving an execute state.
      if (alu_op && cond_ex_reg) begin
        if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
        if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    state_t out_state;
    out_state = reset ? FETCH : state;
    PCWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    RegSrc    = {op == 2'b01, op == 2'b10};
    ImmSrc    = op;
    case (out_state)
      FETCH: begin
        IRWrite = 1'b1; PCWrite = 1'b1;
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMRD:    AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex_reg;
        PCWrite   = cond_ex_reg && (rd == 4'hF);
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex_reg;
      end
      EXECUTEI: ALUSrcB = 2'b01;
      ALUWB: begin
        RegWrite = cond_ex_reg;
        PCWrite  = cond_ex_reg && (rd == 4'hF);
      end
      BRANCH: begin
        ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10;
        PCWrite = cond_ex_reg;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues hand-computed per-cycle
// outputs and flags; a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic [3:0]  alu_flags;
  logic        pc_write, mem_write, reg_write, ir_write, adr_src;
  logic [1:0]  reg_src, alu_src_a, alu_src_b, result_src, imm_src, alu_control;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags),
    .PCWrite(pc_write), .MemWrite(mem_write), .RegWrite(reg_write),
    .IRWrite(ir_write), .AdrSrc(adr_src), .RegSrc(reg_src),
    .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .ResultSrc(result_src),
    .ImmSrc(imm_src), .ALUControl(alu_control)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [16:0] outs;
    logic [3:0]  flags;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] exp_flags;
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic check(input string nm, input logic [16:0] act, input logic [16:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "/outs"},
              {pc_write, mem_write, reg_write, ir_write, adr_src, reg_src,
               alu_src_a, alu_src_b, result_src, imm_src, alu_control}, e.outs);
        check({e.name, "/flags"}, {13'd0, dut.flags}, {13'd0, e.flags});
      end
    end
  end

  // en = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc}; RegSrc/ImmSrc follow Op.
  task automatic cyc(input string nm, input logic [4:0] en, input logic [1:0] asa,
                     input logic [1:0] asb, input logic [1:0] rs, input logic [1:0] alc);
    exp_t       e;
    logic [1:0] op;
    op      = instr[27:26];
    e.name  = nm;
    e.outs  = {en, op == 2'b01, op == 2'b10, asa, asb, rs, op, alc};
    e.flags = exp_flags;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string nm, input logic [31:0] ins);
    instr = ins;
    cyc({nm, ":fetch"},  5'b10010, 2'b01, 2'b10, 2'b10, 2'b00);
    cyc({nm, ":decode"}, 5'b00000, 2'b01, 2'b10, 2'b10, 2'b00);
  endtask

  initial begin
    reset     = 1'b1;
    instr     = 32'hE2821005;
    alu_flags = 4'b1111;
    exp_flags = 4'b0000;
    @(posedge clk); #1;
    cyc("reset", 5'b00000, 2'b01, 2'b10, 2'b10, 2'b00);
    reset = 1'b0;

    // ADD R1,R2,#5: flags untouched although ALUFlags are all ones
    fetch_decode("add", 32'hE2821005);
    cyc("add:execi", 5'b00000, 2'b00, 2'b01, 2'b00, 2'b00);
    cyc("add:aluwb", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00);

    // SUBS R0,R0,R0 -> Z and C set
    fetch_decode("subs", 32'hE0500000);
    alu_flags = 4'b0110;
    cyc("subs:execr", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b01);
    exp_flags = 4'b0110;
    cyc("subs:aluwb", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00);

    // BEQ taken
    fetch_decode("beq_t", 32'h0A000002);
    cyc("beq_t:branch", 5'b10000, 2'b10, 2'b01, 2'b10, 2'b00);

    // ADDS R0,R0,#1 -> all flags cleared
    fetch_decode("adds", 32'hE2900001);
    alu_flags = 4'b0000;
    cyc("adds:execi", 5'b00000, 2'b00, 2'b01, 2'b00, 2'b00);
    exp_flags = 4'b0000;
    cyc("adds:aluwb", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00);

    // BEQ not taken: BRANCH walks but no PCWrite
    fetch_decode("beq_n", 32'h0A000002);
    cyc("beq_n:branch", 5'b00000, 2'b10, 2'b01, 2'b10, 2'b00);

    // LDR R3,[R1,#4]
    fetch_decode("ldr", 32'hE5913004);
    cyc("ldr:memadr", 5'b00000, 2'b00, 2'b01, 2'b00, 2'b00);
    cyc("ldr:memrd",  5'b00001, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("ldr:memwb",  5'b00100, 2'b00, 2'b00, 2'b01, 2'b00);

    // STR R3,[R1,#4]
    fetch_decode("str", 32'hE5813004);
    cyc("str:memadr", 5'b00000, 2'b00, 2'b01, 2'b00, 2'b00);
    cyc("str:memwr",  5'b01001, 2'b00, 2'b00, 2'b00, 2'b00);

    // SUBS again to set Z, then ANDNE fails
    fetch_decode("subs2", 32'hE0500000);
    alu_flags = 4'b0110;
    cyc("subs2:execr", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b01);
    exp_flags = 4'b0110;
    cyc("subs2:aluwb", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00);

    fetch_decode("andne", 32'h10012003);
    alu_flags = 4'b1001;
    cyc("andne:execr", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b10);
    cyc("andne:aluwb", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00);

    // ORRS: only N,Z load -> {1,0} with C,V kept at {1,0}
    fetch_decode("orrs", 32'hE1912003);
    alu_flags = 4'b1001;
    cyc("orrs:execr", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b11);
    exp_flags = 4'b1010;
    cyc("orrs:aluwb", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00);

    // SUBSEQ with Z=0: condition fails, flags and register untouched
    fetch_decode("subseq", 32'h00500000);
    alu_flags = 4'b0101;
    cyc("subseq:execr", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b01);
    cyc("subseq:aluwb", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00);

    // MOVS: unsupported opcode decodes to ADD with no flag write
    fetch_decode("movs", 32'hE1B00000);
    alu_flags = 4'b1111;
    cyc("movs:execr", 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00);
    cyc("movs:aluwb", 5'b00100, 2'b00, 2'b00, 2'b00, 2'b00);

    // ADD PC,R2,#5: writeback to R15 also raises PCWrite
    fetch_decode("add_pc", 32'hE282F005);
    cyc("add_pc:execi", 5'b00000, 2'b00, 2'b01, 2'b00, 2'b00);
    cyc("add_pc:aluwb", 5'b10100, 2'b00, 2'b00, 2'b00, 2'b00);

    // Op=11 returns straight to FETCH after DECODE
    fetch_decode("op11", 32'hEC000000);

    // STR interrupted by reset in MEMWR
    fetch_decode("str_rst", 32'hE5813004);
    cyc("str_rst:memadr", 5'b00000, 2'b00, 2'b01, 2'b00, 2'b00);
    reset = 1'b1;
    cyc("str_rst:reset", 5'b00000, 2'b01, 2'b10, 2'b10, 2'b00);
    reset     = 1'b0;
    exp_flags = 4'b0000;
    cyc("str_rst:fetch", 5'b10010, 2'b01, 2'b10, 2'b10, 2'b00);
    cyc("str_rst:decode", 5'b00000, 2'b01, 2'b10, 2'b10, 2'b00);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
